// File: rtl/job_sequencer.sv
// Avalon-MM controlled job sequencer: launches a datapath job, watches for completion,
// timeout or abort, and reports status plus the cycle count of the last run.
module job_sequencer #(
  parameter logic [31:0] TIMEOUT_RST = 32'd0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        dp_done,
  output logic        dp_start,
  output logic        dp_abort,
  output logic        done_out
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      state_q;
  logic        dp_start_q;
  logic        dp_abort_q;
  logic        done_q;
  logic        timed_out_q;
  logic        aborted_q;
  logic [31:0] cycles_q;
  logic [31:0] timeout_q;

  logic        wr_s;
  logic        ctrl_wr_s;
  logic        start_cmd_s;
  logic        abort_cmd_s;
  logic        clr_cmd_s;
  logic        timeout_wr_s;
  logic        busy_s;
  logic [31:0] cycles_d;

  assign wr_s         = chipselect & ~write_n;
  assign ctrl_wr_s    = wr_s & (address == 2'd0);
  assign start_cmd_s  = ctrl_wr_s & writedata[0] & ~writedata[1];
  assign abort_cmd_s  = ctrl_wr_s & writedata[1];
  assign clr_cmd_s    = ctrl_wr_s & writedata[2];
  assign timeout_wr_s = wr_s & (address == 2'd2);
  assign busy_s       = (state_q == S_START) || (state_q == S_RUN);

  // Saturating increment of the run-cycle counter.
  always_comb begin
    cycles_d = cycles_q;
    if (cycles_q != 32'hFFFF_FFFF) begin
      cycles_d = cycles_q + 32'd1;
    end else begin
      cycles_d = cycles_q;
    end
  end

  // Sequencer FSM with registered pulses, status flags, counter and TIMEOUT register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      dp_start_q  <= 1'b0;
      dp_abort_q  <= 1'b0;
      done_q      <= 1'b0;
      timed_out_q <= 1'b0;
      aborted_q   <= 1'b0;
      cycles_q    <= 32'd0;
      timeout_q   <= TIMEOUT_RST;
    end else begin
      dp_start_q <= 1'b0;
      dp_abort_q <= 1'b0;
      if (timeout_wr_s) begin
        timeout_q <= writedata;
      end
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_cmd_s) begin
            state_q     <= S_START;
            dp_start_q  <= 1'b1;
            done_q      <= 1'b0;
            timed_out_q <= 1'b0;
            aborted_q   <= 1'b0;
            cycles_q    <= 32'd0;
          end else if (clr_cmd_s && (state_q == S_DONE)) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
          end
        end
        S_START: begin
          if (abort_cmd_s) begin
            state_q    <= S_IDLE;
            dp_abort_q <= 1'b1;
            aborted_q  <= 1'b1;
            done_q     <= 1'b0;
          end else begin
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          // Abort freezes the counter; otherwise dp_done outranks the timeout compare.
          if (abort_cmd_s) begin
            state_q    <= S_IDLE;
            dp_abort_q <= 1'b1;
            aborted_q  <= 1'b1;
            done_q     <= 1'b0;
          end else begin
            cycles_q <= cycles_d;
            if (dp_done) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else if ((timeout_q != 32'd0) && (cycles_d == timeout_q)) begin
              state_q     <= S_DONE;
              done_q      <= 1'b1;
              timed_out_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign dp_start = dp_start_q;
  assign dp_abort = dp_abort_q;
  assign done_out = done_q;

  // Zero-wait-state register read mux.
  always_comb begin
    readdata = 32'd0;
    case (address)
      2'd0:    readdata = 32'd0;
      2'd1:    readdata = {28'd0, aborted_q, timed_out_q, done_q, busy_s};
      2'd2:    readdata = timeout_q;
      2'd3:    readdata = cycles_q;
      default: readdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_job_sequencer.sv
// Directed bench for job_sequencer: a run-level reference model checked every cycle,
// plus hand-computed literal expectations for each scenario.
module tb_job_sequencer;

  localparam logic [31:0] TRST = 32'd50;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic        dp_done = 1'b0;
  logic        dp_start;
  logic        dp_abort;
  logic        done_out;

  int vectors = 0;
  int errors  = 0;
  logic [1:0] rot_addr = 2'd0;

  // Reference model: job in flight, first (launch) cycle, result flags.
  bit          m_busy, m_first, m_done, m_to, m_ab, m_abort_p;
  logic [31:0] m_cycles, m_timeout;

  always #10 clk = ~clk;

  job_sequencer #(.TIMEOUT_RST(TRST)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .dp_done(dp_done),
    .dp_start(dp_start), .dp_abort(dp_abort), .done_out(done_out)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [1:0] a);
    case (a)
      2'd1:    return {28'd0, m_ab, m_to, m_done, m_busy};
      2'd2:    return m_timeout;
      2'd3:    return m_cycles;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_busy = 1'b0; m_first = 1'b0; m_done = 1'b0; m_to = 1'b0; m_ab = 1'b0;
    m_abort_p = 1'b0; m_cycles = 32'd0; m_timeout = TRST;
  endtask

  task automatic model_step();
    bit ctrl, start_cmd, abort_cmd, clr_cmd, to_wr;
    if (!reset_n) begin
      model_reset();
      return;
    end
    ctrl      = chipselect && !write_n && (address == 2'd0);
    start_cmd = ctrl && writedata[0] && !writedata[1];
    abort_cmd = ctrl && writedata[1];
    clr_cmd   = ctrl && writedata[2];
    to_wr     = chipselect && !write_n && (address == 2'd2);
    m_abort_p = 1'b0;
    if (m_busy) begin
      if (abort_cmd) begin
        m_busy = 1'b0; m_first = 1'b0; m_ab = 1'b1; m_done = 1'b0; m_abort_p = 1'b1;
      end else if (m_first) begin
        m_first = 1'b0;
      end else begin
        if (m_cycles != 32'hFFFF_FFFF) m_cycles = m_cycles + 32'd1;
        if (dp_done) begin
          m_busy = 1'b0; m_done = 1'b1;
        end else if (m_timeout != 32'd0 && m_cycles == m_timeout) begin
          m_busy = 1'b0; m_done = 1'b1; m_to = 1'b1;
        end
      end
    end else if (start_cmd) begin
      m_busy = 1'b1; m_first = 1'b1; m_done = 1'b0; m_to = 1'b0; m_ab = 1'b0;
      m_cycles = 32'd0;
    end else if (clr_cmd) begin
      m_done = 1'b0;
    end
    if (to_wr) m_timeout = writedata;
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    check("dp_start", {31'd0, dp_start}, {31'd0, m_first});
    check("dp_abort", {31'd0, dp_abort}, {31'd0, m_abort_p});
    check("done_out", {31'd0, done_out}, {31'd0, m_done});
    check("readdata", readdata, exp_rd(address));
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      address = rot_addr;
      rot_addr = rot_addr + 2'd1;
      tick();
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    tick();
    chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
  endtask

  task automatic rd(input string name, input logic [1:0] a, input logic [31:0] exp);
    address = a;
    #1;
    check(name, readdata, exp);
  endtask

  initial begin
    model_reset();
    repeat (2) tick();
    reset_n = 1'b1;
    rd("rst_status", 2'd1, 32'd0);
    rd("rst_timeout", 2'd2, TRST);
    rd("rst_cycles", 2'd3, 32'd0);
    tick();

    // Normal run: dp_done in the 5th RUN cycle.
    wr(2'd2, 32'd0);
    wr(2'd0, 32'd1);
    check("start_pulse", {31'd0, dp_start}, 32'd1);
    idle(1);
    check("start_width", {31'd0, dp_start}, 32'd0);
    idle(4);
    dp_done = 1'b1; idle(1); dp_done = 1'b0;
    check("norm_done_out", {31'd0, done_out}, 32'd1);
    rd("norm_status", 2'd1, 32'h2);
    rd("norm_cycles", 2'd3, 32'd5);
    dp_done = 1'b1; idle(2); dp_done = 1'b0;

    // Timeout run, then CLR_DONE keeps timed_out and CYCLES.
    wr(2'd2, 32'd10);
    wr(2'd0, 32'd1);
    idle(11);
    rd("to_status", 2'd1, 32'h6);
    rd("to_cycles", 2'd3, 32'd10);
    wr(2'd0, 32'd4);
    rd("clr_status", 2'd1, 32'h4);
    rd("clr_cycles", 2'd3, 32'd10);

    // dp_done coincides with timeout.
    wr(2'd2, 32'd3);
    wr(2'd0, 32'd1);
    idle(3);
    dp_done = 1'b1; idle(1); dp_done = 1'b0;
    rd("coin_status", 2'd1, 32'h2);
    rd("coin_cycles", 2'd3, 32'd3);

    // Abort in RUN cycle 2.
    wr(2'd2, 32'd0);
    wr(2'd0, 32'd1);
    idle(2);
    wr(2'd0, 32'd3);
    check("abort_pulse", {31'd0, dp_abort}, 32'd1);
    check("abort_done_out", {31'd0, done_out}, 32'd0);
    rd("abort_status", 2'd1, 32'h8);
    rd("abort_cycles", 2'd3, 32'd1);
    idle(1);
    check("abort_width", {31'd0, dp_abort}, 32'd0);
    wr(2'd0, 32'd1);
    check("restart_pulse", {31'd0, dp_start}, 32'd1);

    // START while busy is ignored; CLR_DONE in DONE.
    idle(1);
    wr(2'd0, 32'd1);
    check("busy_no_start", {31'd0, dp_start}, 32'd0);
    idle(2);
    dp_done = 1'b1; idle(1); dp_done = 1'b0;
    rd("busy_cycles", 2'd3, 32'd4);
    wr(2'd0, 32'd4);
    check("clr_done_out", {31'd0, done_out}, 32'd0);
    rd("clr2_cycles", 2'd3, 32'd4);
    rd("clr2_status", 2'd1, 32'h0);

    // TIMEOUT rewritten mid-run applies to the following compare.
    wr(2'd2, 32'd0);
    wr(2'd0, 32'd1);
    idle(2);
    wr(2'd2, 32'd4);
    idle(2);
    rd("tow_status", 2'd1, 32'h6);
    rd("tow_cycles", 2'd3, 32'd4);

    // START together with CLR_DONE in DONE: START wins.
    wr(2'd0, 32'd5);
    check("startclr_pulse", {31'd0, dp_start}, 32'd1);
    rd("startclr_status", 2'd1, 32'h1);
    idle(6);
    wr(2'd3, 32'h0000_1234);
    rd("cyc_ro", 2'd3, 32'd4);

    // Abort outranks a coincident dp_done; abort straight from START.
    wr(2'd2, 32'd0);
    wr(2'd0, 32'd1);
    idle(2);
    dp_done = 1'b1; wr(2'd0, 32'd2); dp_done = 1'b0;
    rd("abdone_status", 2'd1, 32'h8);
    wr(2'd0, 32'd1);
    wr(2'd0, 32'd2);
    check("abstart_pulse", {31'd0, dp_abort}, 32'd1);
    rd("abstart_cycles", 2'd3, 32'd0);
    idle(2);

    // Asynchronous reset mid-run.
    wr(2'd2, 32'd7);
    wr(2'd0, 32'd1);
    idle(3);
    reset_n = 1'b0;
    model_reset();
    #1;
    check("rst_async_start", {31'd0, dp_start}, 32'd0);
    check("rst_async_abort", {31'd0, dp_abort}, 32'd0);
    rd("rst_async_status", 2'd1, 32'd0);
    rd("rst_async_timeout", 2'd2, TRST);
    rd("rst_async_cycles", 2'd3, 32'd0);
    tick();
    reset_n = 1'b1;
    idle(3);
    rd("post_rst_status", 2'd1, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/job_sequencer.md
JOB_SEQUENCER -- requirements
Module: job_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_RST, default 32'd0: reset value of the TIMEOUT register (0 = timeout disabled).
REQ-002 SHALL have port clk  input  1  system clock; all state is updated on its rising edge.
REQ-003 SHALL have port reset_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port address  input  2  Avalon-MM slave word address.
REQ-005 SHALL have port chipselect  input  1  Avalon-MM slave select.
REQ-006 SHALL have port write_n  input  1  Avalon-MM write strobe, active-low.
REQ-007 SHALL have port writedata  input  32  Avalon-MM write data.
REQ-008 SHALL have port readdata  output  32  Avalon-MM read data; combinational from address, zero wait states.
REQ-009 SHALL have port dp_done  input  1  datapath completion level or pulse.
REQ-010 SHALL have port dp_start  output  1  one-cycle start pulse to the datapath.
REQ-011 SHALL have port dp_abort  output  1  one-cycle abort pulse to the datapath.
REQ-012 SHALL have port done_out  output  1  level completion flag, e.g. for a done PIO or LED.

Function
REQ-013 SHALL accept a write when chipselect=1 and write_n=0.
REQ-014 SHALL decode address 0 as CTRL, write-only: bit0 START, bit1 ABORT, bit2 CLR_DONE; reads return 0.
REQ-015 SHALL decode address 1 as STATUS, read-only: bit0 busy, bit1 done, bit2 timed_out, bit3 aborted; upper bits 0.
REQ-016 SHALL decode address 2 as TIMEOUT, 32-bit read/write, reset value TIMEOUT_RST.
REQ-017 SHALL decode address 3 as CYCLES, read-only cycle count of the last run; writes to it are ignored.
REQ-018 SHALL implement FSM states IDLE, START, RUN and DONE.
REQ-019 SHALL move IDLE->START, or DONE->START, on a CTRL write with START=1 and ABORT=0; entering START SHALL clear done, timed_out, aborted and CYCLES.
REQ-020 SHALL assert dp_start only during the single START cycle, then go START->RUN unconditionally.
REQ-021 SHALL increment CYCLES by 1 each RUN cycle, including the cycle in which dp_done is sampled high, saturating at 32'hFFFFFFFF.
REQ-022 SHALL go RUN->DONE with done=1 when dp_done=1 is sampled in RUN.
REQ-023 SHALL go RUN->DONE with done=1 and timed_out=1 when TIMEOUT!=0, the incremented CYCLES equals TIMEOUT and dp_done=0.
REQ-024 SHALL, on a CTRL write with ABORT=1 in START or RUN, pulse dp_abort for 1 cycle, go to IDLE and set aborted=1, with done=0 and CYCLES frozen.
REQ-025 SHALL give dp_done priority over timeout, and ABORT priority over both, when they coincide in the same cycle.
REQ-026 SHALL ignore a START write in START or RUN, leaving state and counters unchanged.
REQ-027 SHALL ignore dp_done outside RUN.
REQ-028 SHALL, on a CTRL write with CLR_DONE=1 in DONE, go to IDLE with done=0 while preserving CYCLES and timed_out; if START=1 in the same write, START wins.
REQ-029 SHALL drive busy=1 exactly in START and RUN, and done_out equal to the registered done bit.
REQ-030 SHALL take a TIMEOUT write during RUN effect from the next RUN cycle's compare.
REQ-031 SHALL have all outputs registered except readdata.

Reset
REQ-032 SHALL, while reset_n=0, force state=IDLE, dp_start=0, dp_abort=0, done_out=0, done=timed_out=aborted=0, CYCLES=0 and TIMEOUT=TIMEOUT_RST, regardless of clk.
REQ-033 SHALL, on reset assertion mid-run, abandon the run without pulsing dp_abort, and leave state=IDLE after release.

Verification
REQ-034 SHALL pass a normal run: TIMEOUT=0, write CTRL=1, dp_done high 5 cycles after dp_start -> dp_start one cycle wide, STATUS=0x2, CYCLES=5, done_out=1.
REQ-035 SHALL pass a timeout run: TIMEOUT=10, START, dp_done held 0 -> DONE after 10 RUN cycles, STATUS=0x6, CYCLES=10.
REQ-036 SHALL pass a coincidence run: TIMEOUT=3, dp_done=1 in RUN cycle 3 -> STATUS=0x2, timed_out=0, CYCLES=3.
REQ-037 SHALL pass an abort run: START, then CTRL=0x3 in RUN cycle 2 -> dp_abort one cycle, STATUS=0x8, done_out=0; a later START is accepted.
REQ-038 SHALL pass busy/clear: START written during RUN -> no second dp_start; CTRL=0x4 in DONE -> done_out=0, CYCLES retained.
REQ-039 SHALL pass reset mid-run: reset_n low in RUN -> all outputs 0 asynchronously, STATUS=0, TIMEOUT=TIMEOUT_RST.
